// File: rtl/pipeline_hazard_sequencer_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encoding,
// the RegWrite "no write" code and default parameter values.
package pipeline_hazard_sequencer_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MISS_WAIT = 2'd1,
    RESUME    = 2'd2
  } seq_state_t;

  localparam logic [2:0] REGWRITE_NONE    = 3'b000;
  localparam int         DEF_CNT_W        = 32;
  localparam int         DEF_MISS_TIMEOUT = 1024;

endpackage

// File: rtl/pipeline_hazard_sequencer_if.sv
// Control bundle between the pipeline datapath and the hazard sequencer.
// Miss handshake: a miss is accepted in the cycle MemReqM & CacheMissM is
// seen while running; the pipeline then stays frozen until the cache
// returns a single-cycle CacheReadyM pulse, which is only honoured while a
// miss is outstanding and is otherwise ignored.
interface pipeline_hazard_sequencer_if
  import pipeline_hazard_sequencer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [1:0]       RegReadD;
  logic [4:0]       RdE;
  logic [2:0]       RegWriteE;
  logic             MemToRegE;
  logic             JalD;
  logic             JalrE;
  logic             BranchE;
  logic             MemReqM;
  logic             CacheMissM;
  logic             CacheReadyM;
  logic             StallF, StallD, StallE, StallM, StallW;
  logic             FlushF, FlushD, FlushE, FlushM, FlushW;
  logic             MissError;
  logic [CNT_W-1:0] MissCount;
  logic [CNT_W-1:0] StallCycles;

  // Pipeline side: supplies hazard inputs, consumes stage controls.
  modport master (
    output Rs1D, Rs2D, RegReadD, RdE, RegWriteE, MemToRegE,
           JalD, JalrE, BranchE, MemReqM, CacheMissM, CacheReadyM,
    input  StallF, StallD, StallE, StallM, StallW,
           FlushF, FlushD, FlushE, FlushM, FlushW,
           MissError, MissCount, StallCycles
  );

  // Sequencer side.
  modport slave (
    input  Rs1D, Rs2D, RegReadD, RdE, RegWriteE, MemToRegE,
           JalD, JalrE, BranchE, MemReqM, CacheMissM, CacheReadyM,
    output StallF, StallD, StallE, StallM, StallW,
           FlushF, FlushD, FlushE, FlushM, FlushW,
           MissError, MissCount, StallCycles
  );

endinterface

// File: rtl/pipeline_hazard_sequencer_hazard_sat_counter.sv
// Saturating event counter: counts inc cycles, holds at all-ones.
module hazard_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, sticking at the maximum value instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer for a 5-stage RV32I pipeline: load-use interlock,
// branch/JAL/JALR redirect flushes and data-cache miss freeze with a
// timeout flag and performance counters.
module pipeline_hazard_sequencer
  import pipeline_hazard_sequencer_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int MISS_TIMEOUT = DEF_MISS_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  pipeline_hazard_sequencer_if.slave    bus,
  output seq_state_t                    dbg_state
);

  localparam int TMR_W = $clog2(MISS_TIMEOUT + 1);

  seq_state_t       state, state_nxt;
  logic [TMR_W-1:0] timer;
  logic             miss_error;
  logic             miss_hit;
  logic             load_use;
  logic [CNT_W-1:0] miss_cnt;
  logic [CNT_W-1:0] stall_cnt;

  // A new miss is only accepted while running; RESUME ignores CacheMissM
  // so the serviced instruction can leave MEM.
  assign miss_hit = bus.MemReqM & bus.CacheMissM & (state == RUN);

  // EX load writing a register that the ID instruction actually reads.
  assign load_use = bus.MemToRegE
                  & (bus.RegWriteE != REGWRITE_NONE)
                  & (bus.RdE != 5'd0)
                  & ((bus.RegReadD[1] & (bus.Rs1D == bus.RdE))
                   | (bus.RegReadD[0] & (bus.Rs2D == bus.RdE)));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and stage controls; miss freeze beats redirects, redirects
  // beat load-use (wrong-path ID/EX), load-use beats a JAL flush in ID.
  always_comb begin
    state_nxt  = state;
    bus.StallF = 1'b0;
    bus.StallD = 1'b0;
    bus.StallE = 1'b0;
    bus.StallM = 1'b0;
    bus.StallW = 1'b0;
    bus.FlushF = 1'b0;
    bus.FlushD = 1'b0;
    bus.FlushE = 1'b0;
    bus.FlushM = 1'b0;
    bus.FlushW = 1'b0;

    case (state)
      RUN:       if (miss_hit) state_nxt = MISS_WAIT;
      MISS_WAIT: if (bus.CacheReadyM) state_nxt = RESUME;
      RESUME:    state_nxt = RUN;
      default:   state_nxt = RUN;
    endcase

    if (!rst_n) begin
      bus.FlushF = 1'b1;
      bus.FlushD = 1'b1;
      bus.FlushE = 1'b1;
      bus.FlushM = 1'b1;
      bus.FlushW = 1'b1;
    end else if ((state == MISS_WAIT) || miss_hit) begin
      bus.StallF = 1'b1;
      bus.StallD = 1'b1;
      bus.StallE = 1'b1;
      bus.StallM = 1'b1;
      bus.FlushW = 1'b1;
    end else if (bus.BranchE || bus.JalrE) begin
      bus.FlushD = 1'b1;
      bus.FlushE = 1'b1;
    end else if (load_use) begin
      bus.StallF = 1'b1;
      bus.StallD = 1'b1;
      bus.FlushE = 1'b1;
    end else if (bus.JalD) begin
      bus.FlushD = 1'b1;
    end
  end

  // Miss timer runs only in MISS_WAIT; the error flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer      <= '0;
      miss_error <= 1'b0;
    end else if (state == MISS_WAIT) begin
      if (timer != TMR_W'(MISS_TIMEOUT)) timer <= timer + TMR_W'(1);
      if (timer == TMR_W'(MISS_TIMEOUT - 1)) miss_error <= 1'b1;
    end else begin
      timer <= '0;
    end
  end

  hazard_sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_hit),
    .cnt   (miss_cnt)
  );

  hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.StallF),
    .cnt   (stall_cnt)
  );

  assign bus.MissError   = miss_error;
  assign bus.MissCount   = miss_cnt;
  assign bus.StallCycles = stall_cnt;
  assign dbg_state       = state;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Bench for pipeline_hazard_sequencer: per-scenario tasks push expected
// stage-control vectors; a negedge scoreboard pops and compares them.
module tb_pipeline_hazard_sequencer;
  import pipeline_hazard_sequencer_pkg::*;

  localparam int CNT_W      = 32;
  localparam int TB_TIMEOUT = 8;

  // Vector order: {StallF,StallD,StallE,StallM,StallW,FlushF,FlushD,FlushE,FlushM,FlushW}
  localparam logic [9:0] C_NONE = 10'b00000_00000;
  localparam logic [9:0] C_LU   = 10'b11000_00100;
  localparam logic [9:0] C_BR   = 10'b00000_01100;
  localparam logic [9:0] C_JAL  = 10'b00000_01000;
  localparam logic [9:0] C_MISS = 10'b11110_00001;
  localparam logic [9:0] C_RST  = 10'b00000_11111;

  logic       clk = 1'b0;
  logic       rst_n;
  seq_state_t dbg_state;

  int total = 0;
  int bad   = 0;

  logic [9:0]       exp_q[$];
  string            name_q[$];
  logic [CNT_W-1:0] model_miss;
  logic [CNT_W-1:0] model_stall;
  logic [9:0]       mon_got;
  logic [9:0]       mon_want;
  string            mon_nm;

  pipeline_hazard_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_sequencer #(
    .CNT_W        (CNT_W),
    .MISS_TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  // scoreboard: compare stage controls mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_want = exp_q.pop_front();
      mon_nm   = name_q.pop_front();
      mon_got  = {bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.StallW,
                  bus.FlushF, bus.FlushD, bus.FlushE, bus.FlushM, bus.FlushW};
      total++;
      if (mon_got !== mon_want) begin
        bad++;
        $display("FAIL %s ctrl got=%b exp=%b at %0t", mon_nm, mon_got, mon_want, $time);
      end
    end
  end

  // driver tasks
  task automatic idle_inputs();
    bus.Rs1D = 5'd0; bus.Rs2D = 5'd0; bus.RegReadD = 2'b00;
    bus.RdE = 5'd0; bus.RegWriteE = 3'b000; bus.MemToRegE = 1'b0;
    bus.JalD = 1'b0; bus.JalrE = 1'b0; bus.BranchE = 1'b0;
    bus.MemReqM = 1'b0; bus.CacheMissM = 1'b0; bus.CacheReadyM = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [1:0] rr);
    bus.MemToRegE = 1'b1; bus.RegWriteE = 3'b011; bus.RdE = rd;
    bus.Rs1D = rs1; bus.Rs2D = rs2; bus.RegReadD = rr;
  endtask

  // Expect one cycle of controls, then advance to just after the next edge.
  task automatic push_cycle(input logic [9:0] want, input string nm);
    exp_q.push_back(want);
    name_q.push_back(nm);
    if (want[9]) model_stall = model_stall + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    push_cycle(C_RST, "reset_ctrl0");
    push_cycle(C_RST, "reset_ctrl1");
    model_miss = '0; model_stall = '0;
    total++;
    if (dbg_state !== RUN) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, RUN); end
    total++;
    if (bus.MissCount !== '0) begin bad++; $display("FAIL reset_miss_count got=%0d exp=0", bus.MissCount); end
    total++;
    if (bus.StallCycles !== '0) begin bad++; $display("FAIL reset_stall_cycles got=%0d exp=0", bus.StallCycles); end
    total++;
    if (bus.MissError !== 1'b0) begin bad++; $display("FAIL reset_miss_error got=%b exp=0", bus.MissError); end
    rst_n = 1'b1;
    push_cycle(C_NONE, "reset_release");
  endtask

  task automatic test_load_use();
    set_load_use(5'd5, 5'd5, 5'd0, 2'b10);
    push_cycle(C_LU, "load_use_rs1");
    idle_inputs();
    push_cycle(C_NONE, "load_use_after");
    total++;
    if (bus.StallCycles !== 32'd1) begin bad++; $display("FAIL load_use_stall_cycles got=%0d exp=1", bus.StallCycles); end
    set_load_use(5'd9, 5'd1, 5'd9, 2'b01);
    push_cycle(C_LU, "load_use_rs2");
    idle_inputs();
  endtask

  task automatic test_operand_cases();
    set_load_use(5'd0, 5'd0, 5'd0, 2'b11);
    push_cycle(C_NONE, "x0_dest");
    set_load_use(5'd5, 5'd7, 5'd5, 2'b10);
    push_cycle(C_NONE, "rs2_unused");
    set_load_use(5'd5, 5'd5, 5'd0, 2'b10);
    bus.RegWriteE = REGWRITE_NONE;
    push_cycle(C_NONE, "no_regwrite");
    set_load_use(5'd5, 5'd5, 5'd0, 2'b10);
    bus.MemToRegE = 1'b0;
    push_cycle(C_NONE, "not_load");
    idle_inputs();
  endtask

  task automatic test_branch_over_load_use();
    set_load_use(5'd5, 5'd5, 5'd0, 2'b10);
    bus.BranchE = 1'b1;
    push_cycle(C_BR, "branch_over_lu");
    bus.BranchE = 1'b0;
    bus.JalrE = 1'b1;
    push_cycle(C_BR, "jalr_over_lu");
    idle_inputs();
  endtask

  task automatic test_jal();
    bus.JalD = 1'b1;
    push_cycle(C_JAL, "jal_flush");
    set_load_use(5'd4, 5'd4, 5'd0, 2'b10);
    push_cycle(C_LU, "jal_with_lu");
    idle_inputs();
  endtask

  task automatic test_miss_sequence();
    logic [CNT_W-1:0] stall_before;
    stall_before = model_stall;
    bus.MemReqM = 1'b1; bus.CacheMissM = 1'b1;
    model_miss = model_miss + 1;
    push_cycle(C_MISS, "miss_c0");
    total++;
    if (dbg_state !== MISS_WAIT) begin bad++; $display("FAIL miss_state_wait got=%0d exp=%0d", dbg_state, MISS_WAIT); end
    push_cycle(C_MISS, "miss_c1");
    bus.BranchE = 1'b1;
    push_cycle(C_MISS, "miss_c2_over_branch");
    bus.BranchE = 1'b0;
    push_cycle(C_MISS, "miss_c3");
    bus.CacheReadyM = 1'b1;
    push_cycle(C_MISS, "miss_c4_ready");
    bus.CacheReadyM = 1'b0;
    total++;
    if (dbg_state !== RESUME) begin bad++; $display("FAIL miss_state_resume got=%0d exp=%0d", dbg_state, RESUME); end
    push_cycle(C_NONE, "miss_c5_resume");
    idle_inputs();
    total++;
    if (dbg_state !== RUN) begin bad++; $display("FAIL miss_state_run got=%0d exp=%0d", dbg_state, RUN); end
    total++;
    if (bus.MissCount !== model_miss) begin bad++; $display("FAIL miss_count got=%0d exp=%0d", bus.MissCount, model_miss); end
    total++;
    if (bus.StallCycles - stall_before !== 32'd5) begin bad++; $display("FAIL miss_stall_delta got=%0d exp=5", bus.StallCycles - stall_before); end
    // CacheReadyM while running must not disturb anything.
    bus.CacheReadyM = 1'b1;
    push_cycle(C_NONE, "ready_in_run");
    bus.CacheReadyM = 1'b0;
    total++;
    if (dbg_state !== RUN) begin bad++; $display("FAIL ready_in_run_state got=%0d exp=%0d", dbg_state, RUN); end
  endtask

  task automatic test_timeout();
    bus.MemReqM = 1'b1; bus.CacheMissM = 1'b1;
    model_miss = model_miss + 1;
    push_cycle(C_MISS, "timeout_hit");
    for (int k = 1; k <= TB_TIMEOUT + 1; k++) begin
      push_cycle(C_MISS, "timeout_wait");
      total++;
      if (bus.MissError !== (k >= TB_TIMEOUT)) begin
        bad++;
        $display("FAIL timeout_flag k=%0d got=%b exp=%b", k, bus.MissError, (k >= TB_TIMEOUT));
      end
    end
    bus.CacheReadyM = 1'b1;
    push_cycle(C_MISS, "timeout_ready");
    idle_inputs();
    push_cycle(C_NONE, "timeout_resume");
    total++;
    if (bus.MissError !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b exp=1", bus.MissError); end
    total++;
    if (bus.StallCycles !== model_stall) begin bad++; $display("FAIL timeout_stall_cycles got=%0d exp=%0d", bus.StallCycles, model_stall); end
    total++;
    if (bus.MissCount !== model_miss) begin bad++; $display("FAIL timeout_miss_count got=%0d exp=%0d", bus.MissCount, model_miss); end
  endtask

  task automatic test_reset_mid_miss();
    bus.MemReqM = 1'b1; bus.CacheMissM = 1'b1;
    push_cycle(C_MISS, "midrst_hit");
    push_cycle(C_MISS, "midrst_wait");
    rst_n = 1'b0;
    push_cycle(C_RST, "midrst_flush");
    model_miss = '0; model_stall = '0;
    total++;
    if (dbg_state !== RUN) begin bad++; $display("FAIL midrst_state got=%0d exp=%0d", dbg_state, RUN); end
    total++;
    if (bus.MissCount !== '0) begin bad++; $display("FAIL midrst_miss_count got=%0d exp=0", bus.MissCount); end
    total++;
    if (bus.MissError !== 1'b0) begin bad++; $display("FAIL midrst_miss_error got=%b exp=0", bus.MissError); end
    total++;
    if (bus.StallCycles !== '0) begin bad++; $display("FAIL midrst_stall_cycles got=%0d exp=0", bus.StallCycles); end
    idle_inputs();
    rst_n = 1'b1;
    push_cycle(C_NONE, "midrst_release");
    total++;
    if (dbg_state !== RUN) begin bad++; $display("FAIL midrst_run got=%0d exp=%0d", dbg_state, RUN); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] want;
    logic       lu;
    for (int i = 0; i < 40; i++) begin
      bus.Rs1D        = 5'($urandom_range(0, 3));
      bus.Rs2D        = 5'($urandom_range(0, 3));
      bus.RdE         = 5'($urandom_range(0, 3));
      bus.RegReadD    = 2'($urandom_range(0, 3));
      bus.RegWriteE   = 3'($urandom_range(0, 7));
      bus.MemToRegE   = 1'($urandom_range(0, 1));
      bus.JalD        = ($urandom_range(0, 3) == 0);
      bus.JalrE       = ($urandom_range(0, 7) == 0);
      bus.BranchE     = ($urandom_range(0, 7) == 0);
      bus.MemReqM     = 1'b0;
      bus.CacheMissM  = 1'($urandom_range(0, 1));
      bus.CacheReadyM = 1'($urandom_range(0, 1));
      lu = bus.MemToRegE && (bus.RegWriteE != 3'b000) && (bus.RdE != 5'd0) &&
           ((bus.RegReadD[1] && bus.Rs1D == bus.RdE) || (bus.RegReadD[0] && bus.Rs2D == bus.RdE));
      if (bus.BranchE || bus.JalrE) want = C_BR;
      else if (lu)                  want = C_LU;
      else if (bus.JalD)            want = C_JAL;
      else                          want = C_NONE;
      push_cycle(want, "random");
    end
    idle_inputs();
    push_cycle(C_NONE, "random_end");
    total++;
    if (bus.StallCycles !== model_stall) begin bad++; $display("FAIL random_stall_cycles got=%0d exp=%0d", bus.StallCycles, model_stall); end
    total++;
    if (bus.MissCount !== model_miss) begin bad++; $display("FAIL random_miss_count got=%0d exp=%0d", bus.MissCount, model_miss); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_miss  = '0;
    model_stall = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_operand_cases();
    test_branch_over_load_use();
    test_jal();
    test_miss_sequence();
    test_timeout();
    test_reset_mid_miss();
    test_back_to_back();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
